mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory-controller port between instruction-side (port 0, icache refill) and data-side (port 1, dcache refill/writeback) requesters.
- Round-robin arbitration, one outstanding transaction at a time, valid/ready request handshake, one-cycle response pulse back to the granted requester.
- Watchdog converts a hung memory transaction into an error response so the pipeline never deadlocks.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 128, line data width for both write and read data.
- TIMEOUT, 1024, maximum WAIT-state cycles before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pN_req_valid  in  1  port N (N=0,1) request pending; held stable until accepted.
- pN_req_rw  in  1  port N: 1 = write, 0 = read.
- pN_req_addr  in  ADDR_W  port N line address.
- pN_req_wdata  in  DATA_W  port N write data.
- pN_req_ready  out  1  port N request accepted this cycle (combinational).
- pN_res_valid  out  1  port N response, one-cycle pulse.
- pN_res_rdata  out  DATA_W  port N read data; valid with pN_res_valid.
- pN_res_err  out  1  port N transaction timed out; valid with pN_res_valid.
- mem_req_valid  out  1  request to memory controller.
- mem_req_rw, mem_req_addr, mem_req_wdata  out  1/ADDR_W/DATA_W  latched request fields.
- mem_req_ready  in  1  memory controller accepts the request.
- mem_res_valid  in  1  memory controller completion, reads and writes, one pulse.
- mem_res_rdata  in  DATA_W  read data with mem_res_valid.
- busy  out  1  state != IDLE.
- grant_id  out  1  port owning the current transaction; 0 in IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE; all outputs 0; latched request, rdata and err registers 0; last_grant=0, so port 1 wins the first contention.
- IDLE, arbitration:
  - Only one port valid: that port wins.
  - Both valid: the port != last_grant wins.
  - Winner's pN_req_ready=1 combinationally in IDLE only; the loser's ready stays 0.
  - At the edge, latch rw/addr/wdata and grant_id, set last_grant=winner, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields, driven from registers.
  - mem_req_ready=1 moves to WAIT and clears the watchdog counter; otherwise stay.
  - No watchdog in ISSUE.
- WAIT:
  - mem_res_valid=1: capture mem_res_rdata, err=0, go to RESP.
  - Otherwise increment the counter. If TIMEOUT!=0 and counter==TIMEOUT-1 with no mem_res_valid: rdata=0, err=1, go to RESP.
  - mem_res_valid in the same cycle as expiry: treat as a normal completion, err=0.
- RESP:
  - p[grant_id]_res_valid=1 for exactly one cycle with the registered rdata/err; the other port's outputs stay 0.
  - Next state is IDLE.
  - A new request cannot be accepted in RESP; minimum gap between acceptances is 4 cycles.
- mem_res_valid outside WAIT is ignored. A late response after a timeout is dropped.
- Latency: request accepted at edge 0; mem_req_valid in cycle 1; if mem_req_ready=1 in cycle 1 and mem_res_valid=1 in cycle 2, res_valid is in cycle 3.
- Outputs pN_res_rdata/err are 0 when pN_res_valid=0.
- Reset mid-transaction: immediate return to reset values. Any in-flight memory transaction is abandoned; the memory controller is reset by the same rst.
- The counter width covers TIMEOUT-1; no wrap occurs before expiry.

Test Plan:
- Only p0 valid, read addr 0x0000_1000, mem_req_ready=1 in cycle 1, mem_res_valid + rdata 0xDEADBEEF..., in cycle 2 -> p0_req_ready in cycle 0, mem_req_addr=0x1000 in cycle 1, p0_res_valid=1 with that rdata in cycle 3, err=0.
- p0 and p1 valid together three times back-to-back, immediate memory responses -> grants p1, p0, p1, with the loser's req_ready=0 while the other is serviced.
- p1 write addr 0x2000, wdata 0x1234..., mem_req_ready low for 5 cycles -> mem_req_valid held with stable fields for 6 cycles, then WAIT; no timeout is counted during ISSUE.
- TIMEOUT=8, memory never responds -> p_res_valid with err=1 and rdata=0 exactly 8 cycles after entering WAIT; a mem_res_valid arriving 2 cycles later is ignored; busy=0 afterwards.
- rst asserted during WAIT -> all outputs 0 asynchronously; first contention after release grants p1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two cache refill requesters, the arbiter and the
// single memory-controller port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              p0_req_valid;
  logic              p0_req_rw;
  logic [ADDR_W-1:0] p0_req_addr;
  logic [DATA_W-1:0] p0_req_wdata;
  logic              p0_req_ready;
  logic              p0_res_valid;
  logic [DATA_W-1:0] p0_res_rdata;
  logic              p0_res_err;

  logic              p1_req_valid;
  logic              p1_req_rw;
  logic [ADDR_W-1:0] p1_req_addr;
  logic [DATA_W-1:0] p1_req_wdata;
  logic              p1_req_ready;
  logic              p1_res_valid;
  logic [DATA_W-1:0] p1_res_rdata;
  logic              p1_res_err;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_res_valid;
  logic [DATA_W-1:0] mem_res_rdata;

  logic              busy;
  logic              grant_id;

  // Arbiter side.
  modport slave (
    input  p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata,
    input  p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata,
    input  mem_req_ready, mem_res_valid, mem_res_rdata,
    output p0_req_ready, p0_res_valid, p0_res_rdata, p0_res_err,
    output p1_req_ready, p1_res_valid, p1_res_rdata, p1_res_err,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    output busy, grant_id
  );

  // Requesters plus memory controller, seen as one environment.
  modport master (
    output p0_req_valid, p0_req_rw, p0_req_addr, p0_req_wdata,
    output p1_req_valid, p1_req_rw, p1_req_addr, p1_req_wdata,
    output mem_req_ready, mem_res_valid, mem_res_rdata,
    input  p0_req_ready, p0_res_valid, p0_res_rdata, p0_res_err,
    input  p1_req_ready, p1_res_valid, p1_res_rdata, p1_res_err,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between icache (port 0) and
// dcache (port 1), one transaction in flight, with a WAIT-state watchdog.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit WDOG_EN = (TIMEOUT != 0);

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              last_grant_reg, last_grant_next;
  logic              rw_reg, rw_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [1:0]        req_valid;
  logic [1:0]        req_rw;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        req_ready;
  logic [1:0]        res_valid;
  logic [1:0]        res_err;
  logic [DATA_W-1:0] res_rdata [2];
  logic              winner;

  assign req_valid    = {bus.p1_req_valid, bus.p0_req_valid};
  assign req_rw       = {bus.p1_req_rw, bus.p0_req_rw};
  assign req_addr[0]  = bus.p0_req_addr;
  assign req_addr[1]  = bus.p1_req_addr;
  assign req_wdata[0] = bus.p0_req_wdata;
  assign req_wdata[1] = bus.p1_req_wdata;

  // On contention the port that did not win last time gets the grant.
  assign winner = (&req_valid) ? ~last_grant_reg : req_valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = !rst && (state_reg == IDLE) && req_valid[gi]
                             && (winner == 1'(gi));
      assign res_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
      assign res_rdata[gi] = res_valid[gi] ? rdata_reg : '0;
      assign res_err[gi]   = res_valid[gi] & err_reg;
    end
  endgenerate

  assign bus.p0_req_ready  = req_ready[0];
  assign bus.p1_req_ready  = req_ready[1];
  assign bus.p0_res_valid  = res_valid[0];
  assign bus.p1_res_valid  = res_valid[1];
  assign bus.p0_res_rdata  = res_rdata[0];
  assign bus.p1_res_rdata  = res_rdata[1];
  assign bus.p0_res_err    = res_err[0];
  assign bus.p1_res_err    = res_err[1];

  assign bus.mem_req_valid = (state_reg == ISSUE);
  assign bus.mem_req_rw    = rw_reg;
  assign bus.mem_req_addr  = addr_reg;
  assign bus.mem_req_wdata = wdata_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.grant_id      = (state_reg != IDLE) && grant_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
      rw_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      rw_reg         <= rw_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      cnt_reg        <= cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    rw_next         = rw_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          state_next      = ISSUE;
          grant_next      = winner;
          last_grant_next = winner;
          rw_next         = req_rw[winner];
          addr_next       = req_addr[winner];
          wdata_next      = req_wdata[winner];
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        // A completion in the expiry cycle still counts as a good response.
        if (bus.mem_res_valid) begin
          state_next = RESP;
          rdata_next = bus.mem_res_rdata;
          err_next   = 1'b0;
        end else if (WDOG_EN && (cnt_reg == CNT_LAST)) begin
          state_next = RESP;
          rdata_next = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8): single request latency,
// round-robin contention, ISSUE stall, watchdog expiry and async reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports pending: check the grant, serve it with an immediate memory reply.
  task automatic contend(input logic exp_w, input logic [127:0] rd);
    logic [31:0] exp_addr;
    exp_addr = exp_w ? 32'h0000_00B0 : 32'h0000_00A0;
    #1;
    check("rr_ready_p0", bus.p0_req_ready, !exp_w);
    check("rr_ready_p1", bus.p1_req_ready, exp_w);
    tick();
    check("rr_grant", bus.grant_id, exp_w);
    check("rr_addr", bus.mem_req_addr, exp_addr);
    check("rr_loser_ready", bus.p0_req_ready | bus.p1_req_ready, 1'b0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    bus.mem_res_valid = 1'b1;
    bus.mem_res_rdata = rd;
    tick();
    bus.mem_res_valid = 1'b0;
    check("rr_res_win", exp_w ? bus.p1_res_valid : bus.p0_res_valid, 1'b1);
    check("rr_res_lose", exp_w ? bus.p0_res_valid : bus.p1_res_valid, 1'b0);
    check("rr_rdata", exp_w ? bus.p1_res_rdata : bus.p0_res_rdata, rd);
    $display("txn contend: grant=%0d addr=%0h", exp_w, exp_addr);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.p0_req_valid = 0; bus.p0_req_rw = 0; bus.p0_req_addr = '0; bus.p0_req_wdata = '0;
    bus.p1_req_valid = 0; bus.p1_req_rw = 0; bus.p1_req_addr = '0; bus.p1_req_wdata = '0;
    bus.mem_req_ready = 0; bus.mem_res_valid = 0; bus.mem_res_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_grant", bus.grant_id, 1'b0);
    check("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("rst_mem_addr", bus.mem_req_addr, 32'h0);
    rst = 1'b0;

    // Single p0 read: accept at edge 0, response in cycle 3.
    bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 32'h0000_1000;
    #1;
    check("t1_p0_ready", bus.p0_req_ready, 1'b1);
    check("t1_p1_ready", bus.p1_req_ready, 1'b0);
    tick();
    bus.p0_req_valid = 0;
    check("t1_mem_valid", bus.mem_req_valid, 1'b1);
    check("t1_mem_addr", bus.mem_req_addr, 32'h0000_1000);
    check("t1_mem_rw", bus.mem_req_rw, 1'b0);
    check("t1_busy", bus.busy, 1'b1);
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    check("t1_wait_mem_valid", bus.mem_req_valid, 1'b0);
    bus.mem_res_valid = 1;
    bus.mem_res_rdata = 128'hDEADBEEF_00112233_44556677_8899AABB;
    tick();
    bus.mem_res_valid = 0;
    check("t1_res_valid", bus.p0_res_valid, 1'b1);
    check("t1_res_rdata", bus.p0_res_rdata, 128'hDEADBEEF_00112233_44556677_8899AABB);
    check("t1_res_err", bus.p0_res_err, 1'b0);
    check("t1_p1_res", bus.p1_res_valid, 1'b0);
    $display("txn p0 read addr=1000");
    tick();
    check("t1_idle_busy", bus.busy, 1'b0);
    check("t1_idle_res", bus.p0_res_valid, 1'b0);
    check("t1_idle_rdata", bus.p0_res_rdata, 128'h0);

    // Contention three times: p1, p0, p1.
    bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 32'h0000_00A0;
    bus.p1_req_valid = 1; bus.p1_req_rw = 0; bus.p1_req_addr = 32'h0000_00B0;
    contend(1'b1, 128'h1111);
    contend(1'b0, 128'h2222);
    contend(1'b1, 128'h3333);
    bus.p0_req_valid = 0; bus.p1_req_valid = 0;

    // p1 write with memory stalling for 5 cycles in ISSUE.
    bus.p1_req_valid = 1; bus.p1_req_rw = 1; bus.p1_req_addr = 32'h0000_2000;
    bus.p1_req_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    #1;
    check("t3_p1_ready", bus.p1_req_ready, 1'b1);
    tick();
    bus.p1_req_valid = 0;
    for (int i = 0; i < 6; i++) begin
      check("t3_issue_valid", bus.mem_req_valid, 1'b1);
      check("t3_issue_addr", bus.mem_req_addr, 32'h0000_2000);
      check("t3_issue_wdata", bus.mem_req_wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
      check("t3_issue_rw", bus.mem_req_rw, 1'b1);
      bus.mem_req_ready = (i == 5);
      tick();
    end
    bus.mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      check("t3_wait_valid", bus.mem_req_valid, 1'b0);
      check("t3_wait_res", bus.p1_res_valid, 1'b0);
      tick();
    end
    bus.mem_res_valid = 1;
    bus.mem_res_rdata = 128'hC0FFEE;
    tick();
    bus.mem_res_valid = 0;
    check("t3_res_valid", bus.p1_res_valid, 1'b1);
    check("t3_res_err", bus.p1_res_err, 1'b0);
    check("t3_res_grant", bus.grant_id, 1'b1);
    $display("txn p1 write addr=2000 after 5 stall cycles");
    tick();

    // Watchdog: memory never answers; error response 8 cycles after WAIT entry.
    bus.p0_req_valid = 1; bus.p0_req_rw = 0; bus.p0_req_addr = 32'h0000_3000;
    tick();
    bus.p0_req_valid = 0;
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    bus.mem_res_rdata = {4{32'hFFFF_FFFF}};
    for (int i = 0; i < 8; i++) begin
      check("t4_wait_res", bus.p0_res_valid, 1'b0);
      check("t4_wait_busy", bus.busy, 1'b1);
      tick();
    end
    check("t4_to_valid", bus.p0_res_valid, 1'b1);
    check("t4_to_err", bus.p0_res_err, 1'b1);
    check("t4_to_rdata", bus.p0_res_rdata, 128'h0);
    $display("txn p0 read addr=3000 timed out");
    tick();
    check("t4_idle_busy", bus.busy, 1'b0);
    tick();
    bus.mem_res_valid = 1;
    #1;
    check("t4_late_busy", bus.busy, 1'b0);
    tick();
    bus.mem_res_valid = 0;
    check("t4_late_res", bus.p0_res_valid, 1'b0);
    check("t4_late_busy2", bus.busy, 1'b0);

    // Response arriving in the expiry cycle is a normal completion.
    bus.p0_req_valid = 1; bus.p0_req_addr = 32'h0000_3100;
    tick();
    bus.p0_req_valid = 0;
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    repeat (7) tick();
    bus.mem_res_valid = 1;
    bus.mem_res_rdata = 128'hABCD;
    tick();
    bus.mem_res_valid = 0;
    check("t4b_res_valid", bus.p0_res_valid, 1'b1);
    check("t4b_res_err", bus.p0_res_err, 1'b0);
    check("t4b_res_rdata", bus.p0_res_rdata, 128'hABCD);
    $display("txn p0 read addr=3100 completed at expiry");
    tick();

    // Async reset during WAIT of a p1 transaction.
    bus.p1_req_valid = 1; bus.p1_req_rw = 0; bus.p1_req_addr = 32'h0000_4000;
    tick();
    bus.p1_req_valid = 0;
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    tick();
    #2;
    bus.p0_req_valid = 1; bus.p0_req_addr = 32'h0000_00A0;
    bus.p1_req_valid = 1; bus.p1_req_addr = 32'h0000_00B0;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", bus.busy, 1'b0);
    check("t5_rst_grant", bus.grant_id, 1'b0);
    check("t5_rst_mem_valid", bus.mem_req_valid, 1'b0);
    check("t5_rst_mem_addr", bus.mem_req_addr, 32'h0);
    check("t5_rst_ready", {bus.p0_req_ready, bus.p1_req_ready}, 2'b00);
    check("t5_rst_res", {bus.p0_res_valid, bus.p1_res_valid}, 2'b00);
    $display("txn p1 read addr=4000 abandoned by reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_post_p1_ready", bus.p1_req_ready, 1'b1);
    check("t5_post_p0_ready", bus.p0_req_ready, 1'b0);
    tick();
    check("t5_post_grant", bus.grant_id, 1'b1);
    check("t5_post_addr", bus.mem_req_addr, 32'h0000_00B0);
    bus.p0_req_valid = 0; bus.p1_req_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
